// File: rtl/errmod_map_pipe.sv
// Two-stage residual pipeline: sign correction, modulo-RANGE reduction and
// the Golomb-style error mapping, with valid/ready flow control and a per-line index.
module errmod_map_pipe #(
    parameter int BITDEPTH = 8,
    parameter int RES_W    = BITDEPTH + 2,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [RES_W-1:0]    in_err,
    input  logic                in_sign,
    input  logic                in_flip,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITDEPTH-1:0] out_errmod,
    output logic [BITDEPTH-1:0] out_merr,
    output logic                out_last,
    output logic [CNT_W-1:0]    out_count
);

    localparam int RANGE = 1 << BITDEPTH;

    logic                s1_valid_q;
    logic [RES_W:0]      s1_e_q;
    logic                s1_flip_q;
    logic                s1_last_q;

    logic                s2_valid_q;
    logic [BITDEPTH-1:0] errmod_q;
    logic [BITDEPTH-1:0] merr_q;
    logic                last_q;
    logic [CNT_W-1:0]    count_q;

    logic                s2_load;
    logic                s1_adv;
    logic [RES_W:0]      e_d;
    logic signed [RES_W:0] wrapped;
    logic signed [RES_W:0] errmod_wide;
    logic [BITDEPTH-1:0] errmod_d;
    logic [BITDEPTH:0]   twice;
    logic [BITDEPTH-1:0] merr_d;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_adv   = s2_load;
    assign in_ready = !reset && (!s1_valid_q || s1_adv);

    // One extra bit so negating the most negative residual cannot overflow.
    always_comb begin
        e_d = {in_err[RES_W-1], in_err};
        if (in_sign) begin
            e_d = -{in_err[RES_W-1], in_err};
        end
    end

    always_comb begin
        wrapped     = $signed(s1_e_q);
        if (wrapped < 0) begin
            wrapped = wrapped + (RES_W+1)'(RANGE);
        end
        errmod_wide = wrapped;
        if (wrapped >= (RES_W+1)'(RANGE / 2)) begin
            errmod_wide = wrapped - (RES_W+1)'(RANGE);
        end
        errmod_d = BITDEPTH'(errmod_wide);
    end

    // Mapping done modulo RANGE: -2x-1 is ~(2x), and -2(x+1) is ~(2x)-1.
    always_comb begin
        twice = {errmod_d, 1'b0};
        if (!s1_flip_q) begin
            merr_d = errmod_d[BITDEPTH-1] ? BITDEPTH'(~twice) : BITDEPTH'(twice);
        end else begin
            merr_d = errmod_d[BITDEPTH-1] ? BITDEPTH'(~twice - (BITDEPTH+1)'(1))
                                          : BITDEPTH'(twice | (BITDEPTH+1)'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_e_q     <= '0;
            s1_flip_q  <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            errmod_q   <= '0;
            merr_q     <= '0;
            last_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_e_q    <= e_d;
                    s1_flip_q <= in_flip;
                    s1_last_q <= in_last;
                end
            end
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    errmod_q <= errmod_d;
                    merr_q   <= merr_d;
                    last_q   <= s1_last_q;
                end
            end
            // Counter is the index of the word currently presented at the output.
            if (s2_valid_q && out_ready) begin
                count_q <= last_q ? '0 : count_q + CNT_W'(1);
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_errmod = errmod_q;
    assign out_merr   = merr_q;
    assign out_last   = last_q;
    assign out_count  = count_q;

endmodule

// File: tb/tb_errmod_map_pipe.sv
// Bench for errmod_map_pipe: directed corner cases, backpressure, counter and
// reset scenarios plus random traffic scored against an integer reference model.
module tb_errmod_map_pipe;

    localparam int BD = 8;
    localparam int RW = BD + 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] in_err;
    logic          in_sign;
    logic          in_flip;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [BD-1:0] out_errmod;
    logic [BD-1:0] out_merr;
    logic          out_last;
    logic [CW-1:0] out_count;

    always #5 clk = ~clk;

    errmod_map_pipe #(.BITDEPTH(BD), .RES_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_err(in_err),
        .in_sign(in_sign), .in_flip(in_flip), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_errmod(out_errmod), .out_merr(out_merr),
        .out_last(out_last), .out_count(out_count)
    );

    typedef struct {
        logic [7:0] em;
        logic [7:0] mv;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   obs_cnt_q[$];
    int   exp_cnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;

    logic       prev_stall = 1'b0;
    logic       prev_rst = 1'b1;
    logic [7:0] p_em, p_mv;
    logic       p_last;
    logic [CW-1:0] p_cnt;

    function automatic exp_t ref_model(int err, bit sign, bit flip, bit last);
        exp_t r;
        int e, m, em, mv;
        e  = sign ? -err : err;
        m  = ((e % 256) + 256) % 256;
        em = (m >= 128) ? m - 256 : m;
        if (!flip) mv = (em >= 0) ? 2 * em : -2 * em - 1;
        else       mv = (em >= 0) ? 2 * em + 1 : -2 * (em + 1);
        r.em   = em[7:0];
        r.mv   = mv[7:0];
        r.last = last;
        return r;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: input handshakes push model results, output handshakes pop them.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            exp_cnt = 0;
        end else begin
            if (prev_stall && !prev_rst) begin
                check("hold_valid", {31'b0, out_valid}, 1);
                check("hold_errmod", {24'b0, out_errmod}, {24'b0, p_em});
                check("hold_merr", {24'b0, out_merr}, {24'b0, p_mv});
                check("hold_last", {31'b0, out_last}, {31'b0, p_last});
                check("hold_count", {28'b0, out_count}, {28'b0, p_cnt});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output_valid", {31'b0, out_valid}, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_errmod", {24'b0, out_errmod}, {24'b0, e.em});
                    check("sb_merr", {24'b0, out_merr}, {24'b0, e.mv});
                    check("sb_last", {31'b0, out_last}, {31'b0, e.last});
                    check("sb_count", {28'b0, out_count}, 32'(exp_cnt));
                    obs_cnt_q.push_back(int'(out_count));
                    exp_cnt = e.last ? 0 : (exp_cnt + 1) % 16;
                    n_out++;
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(ref_model(int'($signed(in_err)), in_sign, in_flip, in_last));
        end
        prev_stall = out_valid && !out_ready;
        prev_rst   = reset;
        p_em   = out_errmod;
        p_mv   = out_merr;
        p_last = out_last;
        p_cnt  = out_count;
    end

    task automatic send_directed(int err, bit s, bit f, int em, int mv);
        logic [7:0] em8, mv8;
        em8 = em[7:0];
        mv8 = mv[7:0];
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_err    = RW'(err);
        in_sign   = s;
        in_flip   = f;
        in_last   = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat1_valid", {31'b0, out_valid}, 0);
        @(negedge clk);
        check("lat2_valid", {31'b0, out_valid}, 1);
        check("dir_errmod", {24'b0, out_errmod}, {24'b0, em8});
        check("dir_merr", {24'b0, out_merr}, {24'b0, mv8});
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int k = 0; k < 100 && (exp_q.size() != 0 || out_valid); k++) begin
            @(posedge clk); #2;
        end
        check("drain_empty", 32'(exp_q.size()), 0);
    endtask

    // last_idx < 0 selects random line ends; data random unless seq_data.
    task automatic stream(int n, int last_idx, int rdy_pct, int vld_pct, bit seq_data);
        int i = 0;
        for (int g = 0; g < 3000 && i < n; g++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            in_valid  = ($urandom_range(0, 99) < vld_pct);
            in_err    = seq_data ? RW'(i) : RW'(int'($urandom_range(0, 510)) - 255);
            in_sign   = seq_data ? 1'b0 : 1'($urandom_range(0, 1));
            in_flip   = seq_data ? 1'b0 : 1'($urandom_range(0, 1));
            in_last   = (last_idx < 0) ? ($urandom_range(0, 9) == 0) : (i == last_idx);
            #1;
            if (in_valid && in_ready) i++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("stream_complete", 32'(i), 32'(n));
    endtask

    int d_err[8]  = '{-200, 200, 128, -128, 255, 5, 127, -128};
    bit d_sign[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    bit d_flip[8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    int d_em[8]   = '{56, -56, -128, -128, -1, -5, 127, -128};
    int d_mv[8]   = '{112, 111, 255, 255, 1, 9, 255, 254};

    initial begin
        int idx;
        int n_before;
        bit saw_stall;

        reset = 1'b1; in_valid = 1'b0; in_err = '0;
        in_sign = 1'b0; in_flip = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 0);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_count", {28'b0, out_count}, 0);
        check("rst_merr", {24'b0, out_merr}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'b0, in_ready}, 1);
        check("post_rst_out_valid", {31'b0, out_valid}, 0);

        for (int k = 0; k < 8; k++)
            send_directed(d_err[k], d_sign[k], d_flip[k], d_em[k], d_mv[k]);
        drain();

        // Backpressure: out_ready low for cycles 3..5 of a 0..9 stream.
        saw_stall = 1'b0;
        idx = 0;
        n_before = n_out;
        for (int t = 0; t < 60 && idx < 10; t++) begin
            @(posedge clk); #1;
            out_ready = !(t >= 3 && t <= 5);
            in_valid  = 1'b1;
            in_err    = RW'(idx);
            in_sign   = 1'b0;
            in_flip   = 1'b0;
            in_last   = 1'b0;
            #1;
            if (!in_ready) saw_stall = 1'b1;
            if (in_ready) idx++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        check("bp_accepted", 32'(idx), 10);
        check("bp_stall_seen", {31'b0, saw_stall}, 1);
        check("bp_outputs", 32'(n_out - n_before), 10);

        // Counter: align to a line start, then last on the 4th, then a wrap.
        stream(1, 0, 100, 100, 1'b1);
        drain();
        obs_cnt_q.delete();
        stream(6, 3, 100, 100, 1'b1);
        drain();
        stream(16, 99, 100, 100, 1'b1);
        drain();
        check("cnt_log_len", 32'(obs_cnt_q.size()), 22);
        if (obs_cnt_q.size() == 22) begin
            int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
            for (int k = 0; k < 6; k++)
                check("cnt_line", 32'(obs_cnt_q[k]), 32'(exp_seq[k]));
            for (int k = 0; k < 16; k++)
                check("cnt_wrap", 32'(obs_cnt_q[6 + k]), 32'((2 + k) % 16));
        end

        stream(300, -1, 70, 75, 1'b0);
        drain();

        // Reset with both stages full and the output stalled.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_err = RW'(10);
        in_sign = 1'b0; in_flip = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;
        in_err = RW'(20);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("full_in_ready", {31'b0, in_ready}, 0);
        check("full_out_valid", {31'b0, out_valid}, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", {31'b0, in_ready}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {31'b0, out_valid}, 0);
        check("midrst_errmod", {24'b0, out_errmod}, 0);
        check("midrst_merr", {24'b0, out_merr}, 0);
        check("midrst_last", {31'b0, out_last}, 0);
        check("midrst_count", {28'b0, out_count}, 0);
        check("midrst_in_ready1", {31'b0, in_ready}, 1);
        send_directed(7, 0, 0, 7, 14);
        check("midrst_first_count", {28'b0, out_count}, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
